// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-address sequencer.
// Holds the FSM state encoding and the alignment-mask helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } pc_state_e;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned INC_DEF        = 4;
  localparam int unsigned ALIGN_BITS_DEF = 2;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam int unsigned MAX_XLEN       = 64;

  // Mask with the low align_bits cleared; callers slice it down to their XLEN.
  function automatic logic [MAX_XLEN-1:0] align_mask(input int unsigned align_bits);
    logic [MAX_XLEN-1:0] lowOnes;
    lowOnes = (MAX_XLEN'(1) << align_bits) - MAX_XLEN'(1);
    return ~lowOnes;
  endfunction

endpackage

// File: rtl/pc_next_addr.sv
// Next fetch-address datapath: sequential incrementer plus target-select mux.
// Purely combinational; the FSM in pc_sequencer decides when to use it.
module pc_next_addr
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned INC        = INC_DEF,
  parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF
) (
  input  logic [XLEN-1:0] cur_addr_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            pend_valid_i,
  input  logic [XLEN-1:0] pend_addr_i,
  output logic [XLEN-1:0] next_addr_o,
  output logic [XLEN-1:0] aligned_target_o,
  output logic            misaligned_o
);

  localparam logic [MAX_XLEN-1:0] MASK_WIDE = align_mask(ALIGN_BITS);
  localparam logic [XLEN-1:0]     ADDR_MASK = MASK_WIDE[XLEN-1:0];
  localparam logic [XLEN-1:0]     INC_VEC   = XLEN'(INC);

  logic [XLEN-1:0] incAddr;
  logic [XLEN-1:0] targetAddr;
  logic            selTarget;

  assign aligned_target_o = redirect_target_i & ADDR_MASK;
  assign misaligned_o     = |(redirect_target_i & ~ADDR_MASK);

  // Carry-in is zero and the carry-out is dropped, so the PC wraps modulo 2^XLEN.
  assign incAddr = cur_addr_i + INC_VEC;

  // A redirect arriving this cycle is newer than anything pending, so it wins.
  assign targetAddr  = redirect_valid_i ? aligned_target_o : pend_addr_i;
  assign selTarget   = redirect_valid_i | pend_valid_i;
  assign next_addr_o = selTarget ? targetAddr : incAddr;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address controller: owns the PC, drives the req/ack fetch handshake
// and reports each accepted, non-squashed fetch address to decode.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(RESET_ADDR_DEF),
  parameter int unsigned     INC        = INC_DEF,
  parameter int unsigned     ALIGN_BITS = ALIGN_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ack,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_err
);

  pc_state_e       state_q, state_d;
  logic            fetch_req_q, fetch_req_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic            squash_q, squash_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;

  logic [XLEN-1:0] nextAddr;
  logic [XLEN-1:0] alignedTarget;
  logic            targetMisaligned;
  logic            accept;
  logic            squashed;

  pc_next_addr #(
    .XLEN       (XLEN),
    .INC        (INC),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_next_addr (
    .cur_addr_i        (fetch_addr_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pend_valid_i      (pend_valid_q),
    .pend_addr_i       (pend_addr_q),
    .next_addr_o       (nextAddr),
    .aligned_target_o  (alignedTarget),
    .misaligned_o      (targetMisaligned)
  );

  assign accept   = fetch_req_q & fetch_ack;
  assign squashed = redirect_valid | squash_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_out_d     = pc_out_q;
    pc_valid_d   = 1'b0;
    misalign_d   = redirect_valid & targetMisaligned;
    squash_d     = squash_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    unique case (state_q)
      BOOT: begin
        state_d = ISSUE;
        if (redirect_valid) fetch_addr_d = alignedTarget;
      end
      ISSUE: begin
        if (accept) begin
          if (!squashed) begin
            pc_out_d   = fetch_addr_q;
            pc_valid_d = 1'b1;
          end
          fetch_addr_d = nextAddr;
          squash_d     = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = stall ? HOLD : ISSUE;
        end else if (redirect_valid) begin
          // Outstanding request keeps its address; its result is dropped later.
          pend_addr_d  = alignedTarget;
          pend_valid_d = 1'b1;
          squash_d     = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fetch_addr_d = alignedTarget;
          pend_valid_d = 1'b0;
        end
        if (!stall) state_d = ISSUE;
      end
      default: state_d = BOOT;
    endcase
  end

  assign fetch_req_d = (state_d == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= RESET_ADDR;
      pc_out_q     <= '0;
      pc_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
      squash_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      pc_out_q     <= pc_out_d;
      pc_valid_q   <= pc_valid_d;
      misalign_q   <= misalign_d;
      squash_q     <= squash_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign fetch_req    = fetch_req_q;
  assign fetch_addr   = fetch_addr_q;
  assign pc_out       = pc_out_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a behavioural model
// that tracks the fetch stream, pending redirects and delivered PCs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fetch_ack = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        misalign_err;

  int assertCount = 0;
  int failCount   = 0;

  // Model: booting / requesting flags, current address, delivered PC, and the
  // redirects received while a request was outstanding (the newest one wins).
  bit          mBoot;
  bit          mReq;
  bit          mPcValid;
  bit          mMis;
  logic [31:0] mAddr;
  logic [31:0] mPc;
  logic [31:0] mPendQ[$];

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_ack       (fetch_ack),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mBoot    = 1'b1;
    mReq     = 1'b0;
    mPcValid = 1'b0;
    mMis     = 1'b0;
    mAddr    = 32'h0;
    mPc      = 32'h0;
    mPendQ.delete();
  endtask

  task automatic modelStep(input bit s, input bit rv, input logic [31:0] rt, input bit ack);
    logic [31:0] tgt;
    bit          nextValid;
    tgt       = {rt[31:2], 2'b00};
    nextValid = 1'b0;
    if (mBoot) begin
      mBoot = 1'b0;
      mReq  = 1'b1;
      if (rv) mAddr = tgt;
    end else if (mReq) begin
      if (ack) begin
        if (!rv && mPendQ.size() == 0) begin
          mPc       = mAddr;
          nextValid = 1'b1;
        end
        if (rv)                     mAddr = tgt;
        else if (mPendQ.size() > 0) mAddr = mPendQ[$];
        else                        mAddr = mAddr + 32'd4;
        mPendQ.delete();
        mReq = !s;
      end else if (rv) begin
        mPendQ.push_back(tgt);
      end
    end else begin
      if (rv) begin
        mAddr = tgt;
        mPendQ.delete();
      end
      mReq = !s;
    end
    mPcValid = nextValid;
    mMis     = rv && (rt[1:0] != 2'b00);
  endtask

  task automatic checkValue(input string tag, input string sig, input logic [31:0] got,
                            input logic [31:0] exp);
    assertCount++;
    assert (got === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed=%08h expected=%08h", tag, sig, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue(tag, "fetch_req", {31'd0, fetch_req}, {31'd0, mReq});
    checkValue(tag, "fetch_addr", fetch_addr, mAddr);
    checkValue(tag, "pc_valid", {31'd0, pc_valid}, {31'd0, mPcValid});
    checkValue(tag, "pc_out", pc_out, mPc);
    checkValue(tag, "misalign_err", {31'd0, misalign_err}, {31'd0, mMis});
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled likewise.
  task automatic applyStimulus(input string tag, input bit s, input bit rv,
                               input logic [31:0] rt, input bit ack);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt;
    fetch_ack       = ack;
    modelStep(s, rv, rt, ack);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic asyncReset(input string tag);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    fetch_ack      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    checkValue(tag, "req_dropped", {31'd0, fetch_req}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] pc_sequencer bench start");
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus("boot", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("boot", "req_rise", {31'd0, fetch_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("seq", 1'b0, 1'b0, 32'h0, 1'b1);
      checkValue("seq", "pc_const", pc_out, 32'(i * 4));
    end

    applyStimulus("squash_redir", 1'b0, 1'b1, 32'h100, 1'b0);
    checkValue("squash_redir", "addr_held", fetch_addr, 32'h10);
    applyStimulus("squash_acc", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("squash_acc", "no_valid", {31'd0, pc_valid}, 32'd0);
    checkValue("squash_acc", "new_addr", fetch_addr, 32'h100);
    applyStimulus("after_squash", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("after_squash", "pc_const", pc_out, 32'h100);

    applyStimulus("to_20", 1'b0, 1'b1, 32'h20, 1'b1);
    applyStimulus("stall_acc", 1'b1, 1'b0, 32'h0, 1'b1);
    checkValue("stall_acc", "pc_const", pc_out, 32'h20);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus("hold", 1'b1, (i == 2), 32'h40, 1'b1);
      checkValue("hold", "req_low", {31'd0, fetch_req}, 32'd0);
    end
    applyStimulus("resume", 1'b0, 1'b0, 32'h0, 1'b0);
    checkValue("resume", "addr_40", fetch_addr, 32'h40);
    applyStimulus("resume_acc", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("resume_acc", "valid_40", {31'd0, pc_valid}, 32'd1);

    applyStimulus("misalign", 1'b0, 1'b1, 32'h102, 1'b0);
    checkValue("misalign", "err_pulse", {31'd0, misalign_err}, 32'd1);
    applyStimulus("misalign_acc", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("misalign_acc", "err_clear", {31'd0, misalign_err}, 32'd0);
    checkValue("misalign_acc", "addr_100", fetch_addr, 32'h100);

    applyStimulus("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus("wrap_acc", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("wrap_acc", "addr_zero", fetch_addr, 32'h0);
    applyStimulus("outstanding", 1'b0, 1'b0, 32'h0, 1'b0);
    asyncReset("async_reset");

    applyStimulus("reboot", 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus("reboot_acc", 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus("reboot_acc", 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("ack_wait", 1'b0, 1'b0, 32'h0, 1'b0);
      checkValue("ack_wait", "addr_8", fetch_addr, 32'h8);
    end
    applyStimulus("late_ack", 1'b0, 1'b0, 32'h0, 1'b1);
    checkValue("late_ack", "pc_8", pc_out, 32'h8);
    applyStimulus("late_after", 1'b0, 1'b0, 32'h0, 1'b0);
    checkValue("late_after", "single_valid", {31'd0, pc_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      bit          rs;
      bit          rrv;
      bit          rack;
      logic [31:0] rrt;
      if (i == 200) begin
        asyncReset("rand_reset");
      end
      rs   = ($urandom_range(3) == 0);
      rrv  = ($urandom_range(6) == 0);
      rack = ($urandom_range(4) < 3);
      rrt  = $urandom;
      if ($urandom_range(7) == 0) rrt = 32'hFFFF_FFF0 | (rrt & 32'hF);
      applyStimulus("random", rs, rrv, rrt, rack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
